// File: rtl/cnn_fifo_pkg.sv
// Shared definitions for the CNN feature-FIFO read path: word/beat geometry
// and the unpacker control states.
package cnn_fifo_pkg;

    // Width of one FIFO word as stored in the URAM feature FIFO.
    localparam int DATA_WIDTH       = 256;
    // Width of one beat delivered to the conv PE array.
    localparam int OUT_WIDTH        = 64;
    // Beats per FIFO word; the sub-beat index wraps naturally only for powers of 2.
    localparam int RATIO            = DATA_WIDTH / OUT_WIDTH;
    // Width of word counters, matched to the FIFO occupancy count.
    localparam int DATA_COUNT_WIDTH = 17;
    // Bits needed to address one beat lane inside a word.
    localparam int SEL_WIDTH        = (RATIO > 1) ? $clog2(RATIO) : 1;

    // Transfer control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_word_unpacker.sv
// Pops a programmed number of wide words from an FWFT FIFO and replays each
// one as RATIO narrow beats on a valid/ready stream, lane 0 (LSBs) first.
// The last beat of the last word carries m_last; done pulses one cycle later.
module fifo_word_unpacker
    import cnn_fifo_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    // Command interface
    input  logic                        start,
    input  logic [DATA_COUNT_WIDTH-1:0] word_num,
    output logic                        busy,
    output logic                        done,
    // FWFT FIFO read side
    input  logic [DATA_WIDTH-1:0]       fifo_dout,
    input  logic                        fifo_empty,
    output logic                        fifo_rd_en,
    // Narrow output stream
    output logic [OUT_WIDTH-1:0]        m_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic                        m_last
);

    state_t                      state;
    logic [DATA_WIDTH-1:0]       word_buf;
    logic                        buf_valid;
    logic [SEL_WIDTH-1:0]        sel;
    logic [DATA_COUNT_WIDTH-1:0] words_left;

    logic start_accept;
    logic handshake;
    logic sel_last;
    logic last_sub_accepted;
    logic no_words_left;

    // A start is only honoured from IDLE; pulses during RUN/DONE are dropped.
    assign start_accept      = (state == ST_IDLE) && start;
    assign handshake         = buf_valid && m_ready;
    assign sel_last          = (sel == SEL_WIDTH'(RATIO - 1));
    assign last_sub_accepted = handshake && sel_last;
    assign no_words_left     = (words_left == '0);

    // Pop when there is a word to take and the buffer is empty or is being
    // emptied this very cycle; the same-cycle reload gives back-to-back beats
    // across word boundaries. Left combinational so the FWFT head is consumed
    // in the same cycle it is copied into the buffer.
    assign fifo_rd_en = (state == ST_RUN) && !fifo_empty && !no_words_left &&
                        (!buf_valid || last_sub_accepted);

    // Beat lanes come straight out of the held word, so data stays stable
    // for as long as sel and the buffer do, i.e. across any m_ready stall.
    assign m_data  = word_buf[sel*OUT_WIDTH +: OUT_WIDTH];
    assign m_valid = buf_valid;
    assign m_last  = buf_valid && sel_last && no_words_left;

    // Status flags decode directly from the state register, so they are
    // glitch-free and change only on clock edges.
    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    // Transfer control: IDLE -> RUN (or straight to DONE for an empty job)
    // -> DONE after the final beat is accepted -> IDLE.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values of its inputs, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= (word_num != '0) ? ST_RUN : ST_DONE;
                    end
                end
                ST_RUN: begin
                    if (handshake && m_last) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Word buffer, lane select and remaining-word counter.
    // NOTE: word_buf is an ordinary register, not a memory, so it gets an
    // async reset too; that makes m_data read 0 out of reset and after an
    // aborted transfer instead of exposing stale feature data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_buf   <= '0;
            buf_valid  <= 1'b0;
            sel        <= '0;
            words_left <= '0;
        end else if (start_accept) begin
            buf_valid  <= 1'b0;
            sel        <= '0;
            words_left <= word_num;
        end else if (fifo_rd_en) begin
            // A reload also covers the last-sub handshake of the previous word.
            word_buf   <= fifo_dout;
            buf_valid  <= 1'b1;
            sel        <= '0;
            words_left <= words_left - DATA_COUNT_WIDTH'(1);
        end else if (handshake) begin
            sel <= sel + SEL_WIDTH'(1);
            if (sel_last) begin
                buf_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// Self-checking bench for fifo_word_unpacker: a queue-based FWFT FIFO model
// feeds the DUT, a scoreboard holds the expected beats, and a negedge
// monitor compares every accepted beat plus the stream/pop protocol rules.
module tb_fifo_word_unpacker;
    import cnn_fifo_pkg::*;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic                        start = 1'b0;
    logic [DATA_COUNT_WIDTH-1:0] word_num = '0;
    logic                        busy;
    logic                        done;
    logic [DATA_WIDTH-1:0]       fifo_dout;
    logic                        fifo_empty;
    logic                        fifo_rd_en;
    logic [OUT_WIDTH-1:0]        m_data;
    logic                        m_valid;
    logic                        m_ready = 1'b0;
    logic                        m_last;

    fifo_word_unpacker dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .word_num   (word_num),
        .busy       (busy),
        .done       (done),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [OUT_WIDTH-1:0] data;
        logic                 last;
    } beat_t;

    logic [DATA_WIDTH-1:0] fifo_q[$];
    beat_t                 exp_q[$];

    int tests = 0;
    int fails = 0;

    int cycle      = 0;
    int beats      = 0;
    int pops       = 0;
    int done_cnt   = 0;
    int first_beat = -1;
    int last_beat  = -1;

    logic                 pop_pending  = 1'b0;
    logic                 prev_stall   = 1'b0;
    logic                 prev_rd_en   = 1'b0;
    logic                 last_hs_prev = 1'b0;
    logic [OUT_WIDTH-1:0] prev_data    = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function void fifo_refresh();
        fifo_empty = (fifo_q.size() == 0);
        fifo_dout  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
    endfunction

    // Builds a word from lanes base*2^56 + k, shifting each lane in from the
    // top so lane 0 ends up in the LSBs; optionally records the expected beats.
    task automatic push_word(input int base, input bit final_word, input bit expect_beats);
        logic [DATA_WIDTH-1:0] w;
        logic [OUT_WIDTH-1:0]  lane;
        beat_t                 b;
        w = '0;
        for (int k = 0; k < RATIO; k++) begin
            lane = (64'(base) << 56) | 64'(k);
            w = (w >> OUT_WIDTH) | ({lane, {(DATA_WIDTH-OUT_WIDTH){1'b0}}});
            if (expect_beats) begin
                b.data = lane;
                b.last = final_word && (k == RATIO - 1);
                exp_q.push_back(b);
            end
        end
        fifo_q.push_back(w);
        fifo_refresh();
    endtask

    task automatic clear_counts();
        beats      = 0;
        pops       = 0;
        done_cnt   = 0;
        first_beat = -1;
        last_beat  = -1;
    endtask

    task automatic start_xfer(input int n);
        @(posedge clk); #1;
        start    = 1'b1;
        word_num = DATA_COUNT_WIDTH'(n);
        @(posedge clk); #1;
        start    = 1'b0;
        word_num = '0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        tests++;
        assert (n < budget) else begin
            fails++;
            $error("FAIL %s: done not seen within %0d cycles", tag, budget);
        end
    endtask

    // FIFO model: the pop decided at the negedge takes effect just after the
    // edge on which the DUT captured the head word.
    always @(posedge clk) begin
        #1;
        if (pop_pending) begin
            pop_pending = 1'b0;
            pops++;
            void'(fifo_q.pop_front());
            fifo_refresh();
        end
    end

    // Monitor: compares accepted beats against the scoreboard and checks the
    // pop, latency, stall-stability and done-timing rules every cycle.
    always @(negedge clk) begin
        cycle++;
        if (!rst_n) begin
            pop_pending  = 1'b0;
            prev_stall   = 1'b0;
            prev_rd_en   = 1'b0;
            last_hs_prev = 1'b0;
        end else begin
            if (fifo_rd_en) check("rd_en_while_empty", 64'(fifo_empty), 64'(0));
            if (prev_rd_en) check("valid_after_rd_en", 64'(m_valid), 64'(1));
            if (prev_stall) begin
                check("stall_valid_held", 64'(m_valid), 64'(1));
                check("stall_data_held", m_data, prev_data);
            end
            if (last_hs_prev) check("done_after_last", 64'(done), 64'(1));
            if (done) done_cnt++;
            if (m_valid && m_ready) begin
                tests++;
                assert (exp_q.size() != 0) else begin
                    fails++;
                    $error("FAIL beat_unexpected: observed data %h expected no beat", m_data);
                end
                if (exp_q.size() != 0) begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat_data", m_data, e.data);
                    check("beat_last", 64'(m_last), 64'(e.last));
                end
                beats++;
                if (first_beat < 0) first_beat = cycle;
                last_beat = cycle;
            end
            prev_stall   = m_valid && !m_ready;
            prev_data    = m_data;
            prev_rd_en   = fifo_rd_en;
            last_hs_prev = m_valid && m_ready && m_last;
            pop_pending  = fifo_rd_en;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fifo_refresh();
        m_ready = 1'b1;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_rd_en", 64'(fifo_rd_en), 64'(0));
        check("rst_valid", 64'(m_valid), 64'(0));
        check("rst_last", 64'(m_last), 64'(0));
        check("rst_data", m_data, 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 3 preloaded words, m_ready held high: 12 contiguous beats, lane 0 first.
        clear_counts();
        push_word(0, 1'b0, 1'b1);
        push_word(1, 1'b0, 1'b1);
        push_word(2, 1'b1, 1'b1);
        start_xfer(3);
        check("t1_busy", 64'(busy), 64'(1));
        wait_done(100, "t1_done_timeout");
        @(negedge clk);
        check("t1_done_pulse_width", 64'(done), 64'(0));
        check("t1_busy_clear", 64'(busy), 64'(0));
        check("t1_beats", 64'(beats), 64'(12));
        check("t1_done_count", 64'(done_cnt), 64'(1));
        check("t1_pops", 64'(pops), 64'(3));
        check("t1_contiguous", 64'(last_beat - first_beat), 64'(11));
        check("t1_sb_empty", 64'(exp_q.size()), 64'(0));

        // m_ready toggling, 2 words requested with a third sitting in the FIFO,
        // plus a start pulse while busy that must be ignored.
        clear_counts();
        push_word(4, 1'b0, 1'b1);
        push_word(5, 1'b1, 1'b1);
        push_word(6, 1'b0, 1'b0);
        @(posedge clk); #1;
        start    = 1'b1;
        word_num = DATA_COUNT_WIDTH'(2);
        m_ready  = 1'b0;
        for (int n = 0; n < 200 && done_cnt == 0; n++) begin
            @(posedge clk); #1;
            start    = (n == 3);
            word_num = (n == 3) ? DATA_COUNT_WIDTH'(5) : '0;
            m_ready  = ~m_ready;
        end
        start    = 1'b0;
        word_num = '0;
        m_ready  = 1'b1;
        check("t3_done_seen", 64'(done_cnt), 64'(1));
        repeat (4) @(negedge clk);
        check("t3_busy_clear", 64'(busy), 64'(0));
        check("t3_beats", 64'(beats), 64'(8));
        check("t3_pops", 64'(pops), 64'(2));
        check("t3_fifo_left", 64'(fifo_q.size()), 64'(1));
        check("t3_sb_empty", 64'(exp_q.size()), 64'(0));
        fifo_q.delete();
        fifo_refresh();

        // FIFO runs dry after the first of 4 words, then refills.
        clear_counts();
        push_word(7, 1'b0, 1'b1);
        start_xfer(4);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("t4_dry_valid", 64'(m_valid), 64'(0));
        check("t4_dry_rd_en", 64'(fifo_rd_en), 64'(0));
        check("t4_dry_beats", 64'(beats), 64'(4));
        check("t4_dry_busy", 64'(busy), 64'(1));
        @(posedge clk); #1;
        push_word(8, 1'b0, 1'b1);
        push_word(9, 1'b0, 1'b1);
        push_word(10, 1'b1, 1'b1);
        wait_done(100, "t4_done_timeout");
        @(negedge clk);
        check("t4_beats", 64'(beats), 64'(16));
        check("t4_pops", 64'(pops), 64'(4));
        check("t4_sb_empty", 64'(exp_q.size()), 64'(0));

        // Zero-length job: no pop, done one cycle after start, busy for 1 cycle.
        clear_counts();
        push_word(11, 1'b0, 1'b0);
        @(posedge clk); #1;
        start    = 1'b1;
        word_num = '0;
        @(negedge clk);
        check("t5_busy_before", 64'(busy), 64'(0));
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("t5_done", 64'(done), 64'(1));
        check("t5_busy", 64'(busy), 64'(1));
        check("t5_rd_en", 64'(fifo_rd_en), 64'(0));
        @(negedge clk);
        check("t5_done_clear", 64'(done), 64'(0));
        check("t5_busy_clear", 64'(busy), 64'(0));
        repeat (2) @(negedge clk);
        check("t5_pops", 64'(pops), 64'(0));
        check("t5_beats", 64'(beats), 64'(0));
        fifo_q.delete();
        fifo_refresh();

        // Reset in the middle of a word (sel == 2), then a clean new job.
        clear_counts();
        push_word(12, 1'b0, 1'b1);
        push_word(13, 1'b1, 1'b1);
        start_xfer(2);
        for (int n = 0; n < 50 && beats < 2; n++) begin
            @(posedge clk); #2;
        end
        check("t6_beats_before_rst", 64'(beats), 64'(2));
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", 64'(busy), 64'(0));
        check("t6_rst_done", 64'(done), 64'(0));
        check("t6_rst_rd_en", 64'(fifo_rd_en), 64'(0));
        check("t6_rst_valid", 64'(m_valid), 64'(0));
        check("t6_rst_last", 64'(m_last), 64'(0));
        check("t6_rst_data", m_data, 64'(0));
        exp_q.delete();
        fifo_q.delete();
        fifo_refresh();
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_counts();
        push_word(14, 1'b1, 1'b1);
        start_xfer(1);
        wait_done(50, "t6_done_timeout");
        @(negedge clk);
        check("t6_beats", 64'(beats), 64'(4));
        check("t6_pops", 64'(pops), 64'(1));
        check("t6_sb_empty", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
